// File: rtl/reward_sequencer_pkg.sv
// Shared definitions for the lick-gated reward sequencer: state encoding,
// outcome codes and default timing parameters.
package reward_sequencer_pkg;

  localparam int unsigned MS_DIV_DEFAULT     = 1000;
  localparam int unsigned REFRACT_MS_DEFAULT = 500;
  localparam int unsigned CNT_W_DEFAULT      = 16;
  localparam int unsigned NUM_PORTS          = 4;
  localparam int unsigned WRONG_W            = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_REWARD  = 2'd2;
  localparam logic [1:0] ST_REFRACT = 2'd3;

  typedef enum logic [1:0] {
    OUT_NONE    = 2'd0,
    OUT_REWARD  = 2'd1,
    OUT_TIMEOUT = 2'd2,
    OUT_ABORT   = 2'd3
  } outcome_e;

  // One-hot mask selecting a lick/valve port.
  function automatic logic [NUM_PORTS-1:0] port_mask(input logic [1:0] port);
    return NUM_PORTS'(1) << port;
  endfunction

endpackage

// File: rtl/reward_sequencer_if.sv
// Host/lick/valve signal bundle between the trial controller and its environment.
interface reward_sequencer_if
  import reward_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);
  logic                 arm;
  logic [1:0]           arm_port;
  logic [CNT_W-1:0]     timeout_ms;
  logic                 abort;
  logic [NUM_PORTS-1:0] lick;
  logic [NUM_PORTS-1:0] valve_trig;
  logic                 busy;
  logic                 done;
  logic [1:0]           outcome;
  logic [WRONG_W-1:0]   wrong_licks;
  logic [CNT_W-1:0]     reward_count;

  modport master (
    output arm, arm_port, timeout_ms, abort, lick,
    input  valve_trig, busy, done, outcome, wrong_licks, reward_count
  );

  modport slave (
    input  arm, arm_port, timeout_ms, abort, lick,
    output valve_trig, busy, done, outcome, wrong_licks, reward_count
  );
endinterface

// File: rtl/reward_sequencer_ms_timer.sv
// Millisecond prescaler plus ms counter; expired rises on the tick where the
// count reaches limit. Shared by trial timeout and refractory timing.
module reward_sequencer_ms_timer #(
  parameter int unsigned MS_DIV = 1000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] ms_cnt;
  logic             tick_c;

  assign tick_c = enable && (presc == PW'(MS_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      ms_cnt  <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      presc   <= '0;
      ms_cnt  <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      presc <= tick_c ? '0 : presc + 1'b1;
      if (tick_c) begin
        ms_cnt  <= ms_cnt + 1'b1;
        expired <= (CNT_W'(ms_cnt + 1'b1) == limit);
      end
    end
  end

endmodule

// File: rtl/reward_sequencer.sv
// Lick-gated reward controller: waits for a fresh lick on the armed port,
// fires one valve trigger, holds a refractory period and reports the outcome.
module reward_sequencer
  import reward_sequencer_pkg::*;
#(
  parameter int unsigned MS_DIV     = MS_DIV_DEFAULT,
  parameter int unsigned REFRACT_MS = REFRACT_MS_DEFAULT,
  parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  reward_sequencer_if.slave bus
);

  logic [1:0]           state, state_d;
  logic [1:0]           port_q, port_d;
  logic [CNT_W-1:0]     timeout_q, timeout_d;
  logic [NUM_PORTS-1:0] lick_q;
  logic [NUM_PORTS-1:0] rise_c, port_mask_c, wrong_rise_c;
  logic [NUM_PORTS-1:0] valve_q, valve_d;
  logic                 busy_q;
  logic                 done_q, done_d;
  outcome_e             outcome_q, outcome_d;
  logic [WRONG_W-1:0]   wrong_q, wrong_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 timer_clear_c, timer_en_c, expired;
  logic [CNT_W-1:0]     timer_limit_c;

  assign rise_c       = bus.lick & ~lick_q;
  assign port_mask_c  = port_mask(port_q);
  assign wrong_rise_c = rise_c & ~port_mask_c;

  reward_sequencer_ms_timer #(
    .MS_DIV (MS_DIV),
    .CNT_W  (CNT_W)
  ) u_ms_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear_c),
    .enable  (timer_en_c),
    .limit   (timer_limit_c),
    .expired (expired)
  );

  // Next-state and next-output logic; abort beats reward beats timeout.
  always_comb begin
    state_d       = state;
    port_d        = port_q;
    timeout_d     = timeout_q;
    valve_d       = '0;
    done_d        = 1'b0;
    outcome_d     = outcome_q;
    wrong_d       = wrong_q;
    count_d       = count_q;
    timer_clear_c = 1'b0;
    timer_en_c    = 1'b0;
    timer_limit_c = timeout_q;

    case (state)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d       = ST_ARMED;
          port_d        = bus.arm_port;
          timeout_d     = bus.timeout_ms;
          wrong_d       = '0;
          outcome_d     = OUT_NONE;
          timer_clear_c = 1'b1;
        end
      end
      ST_ARMED: begin
        timer_en_c = (timeout_q != '0);
        if (|wrong_rise_c) begin
          wrong_d = (wrong_q == '1) ? wrong_q : wrong_q + 1'b1;
        end
        if (bus.abort) begin
          state_d   = ST_IDLE;
          outcome_d = OUT_ABORT;
          done_d    = 1'b1;
        end else if (|(rise_c & port_mask_c)) begin
          state_d   = ST_REWARD;
          valve_d   = port_mask_c;
          count_d   = count_q + 1'b1;
          outcome_d = OUT_REWARD;
        end else if (timer_en_c && expired) begin
          state_d   = ST_IDLE;
          outcome_d = OUT_TIMEOUT;
          done_d    = 1'b1;
        end
      end
      ST_REWARD: begin
        state_d       = ST_REFRACT;
        timer_clear_c = 1'b1;
      end
      ST_REFRACT: begin
        timer_en_c    = 1'b1;
        timer_limit_c = CNT_W'(REFRACT_MS);
        if (bus.abort || expired) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      port_q    <= '0;
      timeout_q <= '0;
      lick_q    <= '0;
      valve_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      outcome_q <= OUT_NONE;
      wrong_q   <= '0;
      count_q   <= '0;
    end else begin
      state     <= state_d;
      port_q    <= port_d;
      timeout_q <= timeout_d;
      lick_q    <= bus.lick;
      valve_q   <= valve_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      outcome_q <= outcome_d;
      wrong_q   <= wrong_d;
      count_q   <= count_d;
    end
  end

  assign bus.valve_trig   = valve_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.outcome      = outcome_q;
  assign bus.wrong_licks  = wrong_q;
  assign bus.reward_count = count_q;

endmodule

// File: tb/tb_reward_sequencer.sv
// Self-checking bench for reward_sequencer: directed trials plus randomized
// trials predicted by an event-level model (first correct rise / abort / timeout).
module tb_reward_sequencer;

  localparam int unsigned D   = 10;
  localparam int unsigned RMS = 5;
  localparam int unsigned CW  = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_rc   = 0;
  int   arm_cyc  = 0;

  int vpulse [4];
  int vtotal = 0, multi_hot = 0, done_cnt = 0, last_done_cyc = 0, last_valve_cyc = 0;

  reward_sequencer_if #(.CNT_W(CW)) bus ();

  reward_sequencer #(.MS_DIV(D), .REFRACT_MS(RMS), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: valve/done events with the cycle they were seen.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 4; i++) if (bus.valve_trig[i]) vpulse[i] = vpulse[i] + 1;
      if (bus.valve_trig != 4'd0) begin
        vtotal = vtotal + 1;
        last_valve_cyc = cyc;
      end
      if ($countones(bus.valve_trig) > 1) multi_hot = multi_hot + 1;
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm(input logic [1:0] p, input logic [15:0] t);
    bus.arm_port   = p;
    bus.timeout_ms = t;
    bus.arm        = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
    arm_cyc = cyc;
  endtask

  task automatic wait_done(input int db, input int budget);
    #1;
    while (done_cnt == db && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
  endtask

  task automatic test_reset();
    bus.arm = 0; bus.arm_port = 0; bus.timeout_ms = 0; bus.abort = 0; bus.lick = 0;
    reset_n = 1'b0;
    tick(3);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.valve_trig !== 4'd0) $display("FAIL reset_valve got=%b exp=0000", bus.valve_trig); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd0) $display("FAIL reset_outcome got=%0d exp=0", bus.outcome); else n_pass++;
    n_checks++; if (bus.reward_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", bus.reward_count); else n_pass++;
    n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
    n_checks++; if (bus.wrong_licks !== 8'd0) $display("FAIL reset_wrong got=%0d exp=0", bus.wrong_licks); else n_pass++;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_reward();
    int db, vc;
    bus.lick = 4'd0;
    tick(2);
    db = done_cnt;
    do_arm(2'd2, 16'd100);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL rew_busy got=%b exp=1", bus.busy); else n_pass++;
    tick(40 * D - 1);
    bus.lick = 4'b0100;
    @(negedge clk);
    vc = cyc;
    exp_rc++;
    n_checks++; if (bus.valve_trig !== 4'b0100) $display("FAIL rew_valve got=%b exp=0100", bus.valve_trig); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.valve_trig !== 4'b0000) $display("FAIL rew_valve_width got=%b exp=0000", bus.valve_trig); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd1) $display("FAIL rew_outcome got=%0d exp=1", bus.outcome); else n_pass++;
    n_checks++; if (bus.reward_count !== 16'(exp_rc)) $display("FAIL rew_count got=%0d exp=%0d", bus.reward_count, exp_rc); else n_pass++;
    wait_done(db, RMS * D + 20);
    n_checks++; if (done_cnt != db + 1) $display("FAIL rew_done_count got=%0d exp=1", done_cnt - db); else n_pass++;
    n_checks++;
    if ((last_done_cyc - vc) < int'(RMS * D) - 3 || (last_done_cyc - vc) > int'(RMS * D) + 3)
      $display("FAIL rew_refract_len got=%0d exp=%0d", last_done_cyc - vc, RMS * D);
    else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rew_idle_busy got=%b exp=0", bus.busy); else n_pass++;
    bus.lick = 4'd0;
    tick(2);
  endtask

  task automatic test_timeout();
    int db, vb, a, diff;
    bus.lick = 4'd0;
    db = done_cnt; vb = vtotal;
    do_arm(2'd1, 16'd5);
    a = arm_cyc;
    wait_done(db, 10 * D);
    diff = last_done_cyc - (a + 5 * int'(D));
    n_checks++; if (done_cnt != db + 1) $display("FAIL tmo_done got=%0d exp=1", done_cnt - db); else n_pass++;
    n_checks++; if (diff < -1 || diff > 1) $display("FAIL tmo_time got=%0d exp=%0d", last_done_cyc - a, 5 * D); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd2) $display("FAIL tmo_outcome got=%0d exp=2", bus.outcome); else n_pass++;
    n_checks++; if (vtotal != vb) $display("FAIL tmo_valve got=%0d exp=0", vtotal - vb); else n_pass++;
    tick(2);
  endtask

  task automatic test_held_lick();
    int db, vb;
    bus.lick = 4'b0001;
    tick(2);
    db = done_cnt; vb = vtotal;
    do_arm(2'd0, 16'd0);
    tick(3);
    for (int i = 0; i < 3; i++) begin
      bus.lick[3] = 1'b1; tick(2);
      bus.lick[3] = 1'b0; tick(2);
    end
    n_checks++; if (vtotal != vb) $display("FAIL held_no_reward got=%0d exp=0", vtotal - vb); else n_pass++;
    n_checks++; if (bus.wrong_licks !== 8'd3) $display("FAIL held_wrong got=%0d exp=3", bus.wrong_licks); else n_pass++;
    bus.lick[0] = 1'b0; tick(2);
    bus.lick[0] = 1'b1;
    @(negedge clk);
    exp_rc++;
    n_checks++; if (bus.valve_trig !== 4'b0001) $display("FAIL held_valve got=%b exp=0001", bus.valve_trig); else n_pass++;
    wait_done(db, RMS * D + 20);
    n_checks++; if (bus.reward_count !== 16'(exp_rc)) $display("FAIL held_count got=%0d exp=%0d", bus.reward_count, exp_rc); else n_pass++;
    bus.lick = 4'd0;
    tick(2);
  endtask

  task automatic test_abort();
    int db, vb;
    db = done_cnt;
    bus.abort = 1'b1; tick(1); bus.abort = 1'b0; tick(2);
    n_checks++; if (done_cnt != db || bus.busy !== 1'b0) $display("FAIL idle_abort done=%0d busy=%b exp=0/0", done_cnt - db, bus.busy); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd1) $display("FAIL idle_abort_outcome got=%0d exp=1", bus.outcome); else n_pass++;
    bus.lick = 4'd0;
    vb = vtotal;
    do_arm(2'd0, 16'd0);
    tick(1000 * D);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++; if (bus.done !== 1'b1) $display("FAIL abort_done got=%b exp=1", bus.done); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd3) $display("FAIL abort_outcome got=%0d exp=3", bus.outcome); else n_pass++;
    bus.lick = 4'b0001; tick(3);
    n_checks++; if (vtotal != vb) $display("FAIL abort_late_lick got=%0d exp=0", vtotal - vb); else n_pass++;
    bus.lick = 4'd0; tick(2);
    do_arm(2'd0, 16'd0);
    tick(5);
    bus.lick = 4'b0001; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.outcome !== 2'd3) $display("FAIL abort_tie done=%b outcome=%0d exp=1/3", bus.done, bus.outcome); else n_pass++;
    tick(2);
    n_checks++; if (vtotal != vb) $display("FAIL abort_tie_valve got=%0d exp=0", vtotal - vb); else n_pass++;
    bus.lick = 4'd0; tick(2);
  endtask

  task automatic test_refract_arm();
    int db;
    bus.lick = 4'd0;
    db = done_cnt;
    do_arm(2'd3, 16'd0);
    tick(4);
    bus.lick = 4'b1000;
    @(negedge clk);
    exp_rc++;
    tick(5);
    do_arm(2'd1, 16'd7);
    tick(2);
    n_checks++; if (bus.busy !== 1'b1 || bus.outcome !== 2'd1) $display("FAIL refr_arm busy=%b outcome=%0d exp=1/1", bus.busy, bus.outcome); else n_pass++;
    n_checks++; if (bus.reward_count !== 16'(exp_rc)) $display("FAIL refr_arm_count got=%0d exp=%0d", bus.reward_count, exp_rc); else n_pass++;
    wait_done(db, RMS * D + 20);
    tick(3);
    n_checks++; if (done_cnt != db + 1 || bus.busy !== 1'b0) $display("FAIL refr_arm_done got=%0d busy=%b exp=1/0", done_cnt - db, bus.busy); else n_pass++;
    bus.lick = 4'd0; tick(2);
    db = done_cnt;
    do_arm(2'd3, 16'd0);
    tick(2);
    bus.lick = 4'b1000;
    @(negedge clk);
    exp_rc++;
    tick(4);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.outcome !== 2'd1) $display("FAIL refr_abort done=%b outcome=%0d exp=1/1", bus.done, bus.outcome); else n_pass++;
    tick(2);
    n_checks++; if (done_cnt != db + 1) $display("FAIL refr_abort_once got=%0d exp=1", done_cnt - db); else n_pass++;
    bus.lick = 4'd0; tick(2);
  endtask

  task automatic test_wrong_sat();
    int vb;
    bus.lick = 4'd0;
    vb = vtotal;
    do_arm(2'd0, 16'd0);
    for (int i = 0; i < 300; i++) begin
      bus.lick = 4'b0010; tick(1);
      bus.lick = 4'b0000; tick(1);
    end
    n_checks++; if (bus.wrong_licks !== 8'd255) $display("FAIL wrong_sat got=%0d exp=255", bus.wrong_licks); else n_pass++;
    n_checks++; if (vtotal != vb) $display("FAIL wrong_valve got=%0d exp=0", vtotal - vb); else n_pass++;
    bus.abort = 1'b1; tick(1); bus.abort = 1'b0; tick(2);
    do_arm(2'd1, 16'd0);
    n_checks++; if (bus.wrong_licks !== 8'd0 || bus.outcome !== 2'd0) $display("FAIL rearm_clear wrong=%0d outcome=%0d exp=0/0", bus.wrong_licks, bus.outcome); else n_pass++;
    bus.abort = 1'b1; tick(1); bus.abort = 1'b0; tick(2);
  endtask

  // Random trials; the model picks the single ending event and counts
  // wrong-port rising edges that precede it.
  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [3:0] lk [0:63];
      logic [3:0] held, prev, pmask, v;
      int p, kind, k_ev, tmo, wexp, a, db, vb, vpb, exp_out, diff;
      p     = int'($urandom_range(0, 3));
      kind  = int'($urandom_range(0, 2));
      pmask = 4'b0001 << p;
      if (kind == 2) begin
        tmo  = int'($urandom_range(1, 4));
        k_ev = tmo * int'(D);
      end else begin
        k_ev = int'($urandom_range(3, 45));
        tmo  = ($urandom_range(0, 1) == 0) ? 0 : k_ev / int'(D) + 2 + int'($urandom_range(0, 2));
      end
      held = 4'($urandom);
      prev = held;
      for (int k = 0; k < 64; k++) begin
        v = prev ^ (4'($urandom) & 4'($urandom));
        if (k == 0) v[p] = held[p];
        else v[p] = (kind == 0 && k >= k_ev);
        if (k >= k_ev - 1 && k <= k_ev) v = (v & pmask) | (prev & ~pmask);
        lk[k] = v;
        prev  = v;
      end
      wexp = 0;
      prev = held;
      for (int k = 0; k < k_ev; k++) begin
        if ((lk[k] & ~prev & ~pmask) != 4'd0) wexp++;
        prev = lk[k];
      end
      if (wexp > 255) wexp = 255;
      exp_out = (kind == 0) ? 1 : (kind == 1) ? 3 : 2;

      bus.lick = held;
      tick(2);
      db = done_cnt; vb = vtotal; vpb = vpulse[p];
      do_arm(2'(p), 16'(tmo));
      a = arm_cyc;
      for (int k = 0; k <= k_ev; k++) begin
        bus.lick  = lk[k];
        bus.abort = (kind == 1 && k == k_ev);
        @(negedge clk);
      end
      bus.abort = 1'b0;
      wait_done(db, RMS * D + 30);
      if (kind == 0) exp_rc++;
      tick(3);
      n_checks++; if (bus.outcome !== 2'(exp_out)) $display("FAIL rnd%0d_outcome got=%0d exp=%0d", t, bus.outcome, exp_out); else n_pass++;
      n_checks++; if (bus.wrong_licks !== 8'(wexp)) $display("FAIL rnd%0d_wrong got=%0d exp=%0d", t, bus.wrong_licks, wexp); else n_pass++;
      n_checks++; if (bus.reward_count !== 16'(exp_rc)) $display("FAIL rnd%0d_count got=%0d exp=%0d", t, bus.reward_count, exp_rc); else n_pass++;
      n_checks++;
      if (vtotal - vb != (kind == 0 ? 1 : 0) || vpulse[p] - vpb != (kind == 0 ? 1 : 0))
        $display("FAIL rnd%0d_valve got=%0d/%0d exp=%0d", t, vtotal - vb, vpulse[p] - vpb, kind == 0 ? 1 : 0);
      else n_pass++;
      n_checks++; if (done_cnt - db != 1) $display("FAIL rnd%0d_done got=%0d exp=1", t, done_cnt - db); else n_pass++;
      n_checks++;
      if (kind == 0) begin
        if (last_valve_cyc != a + k_ev + 1) $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, last_valve_cyc - a, k_ev + 1);
        else n_pass++;
      end else if (kind == 1) begin
        if (last_done_cyc != a + k_ev + 1) $display("FAIL rnd%0d_abort_time got=%0d exp=%0d", t, last_done_cyc - a, k_ev + 1);
        else n_pass++;
      end else begin
        diff = last_done_cyc - (a + k_ev);
        if (diff < -1 || diff > 1) $display("FAIL rnd%0d_tmo_time got=%0d exp=%0d", t, last_done_cyc - a, k_ev);
        else n_pass++;
      end
    end
    bus.lick = 4'd0;
    tick(2);
  endtask

  task automatic test_reset_mid_armed();
    bus.lick = 4'd0;
    do_arm(2'd2, 16'd0);
    bus.lick = 4'b0001; tick(3);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.valve_trig !== 4'd0) $display("FAIL mid_reset_valve got=%b exp=0000", bus.valve_trig); else n_pass++;
    n_checks++; if (bus.outcome !== 2'd0) $display("FAIL mid_reset_outcome got=%0d exp=0", bus.outcome); else n_pass++;
    n_checks++; if (bus.reward_count !== 16'd0) $display("FAIL mid_reset_count got=%0d exp=0", bus.reward_count); else n_pass++;
    n_checks++; if (bus.wrong_licks !== 8'd0) $display("FAIL mid_reset_wrong got=%0d exp=0", bus.wrong_licks); else n_pass++;
    exp_rc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.lick = 4'd0;
    tick(3);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", bus.busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reward();
    test_timeout();
    test_held_lick();
    test_abort();
    test_refract_arm();
    test_wrong_sat();
    test_random(20);
    test_reset_mid_armed();
    n_checks++; if (multi_hot != 0) $display("FAIL valve_onehot got=%0d exp=0", multi_hot); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reward_sequencer.md
Name: reward_sequencer

Overview:
- Lick-gated reward controller in the clk_1mhz domain.
- Sits between the debounced lick inputs and the four valve_driver instances. Replaces direct host triggering of valve0..3 during trials.
- Host arms one port with a timeout. The block waits for a fresh lick on that port, then emits a single valve trigger pulse, enforces a refractory period, and reports the outcome through a status wire.

Parameters:
- MS_DIV, 1000, clk cycles per millisecond tick (1 MHz clock).
- REFRACT_MS, 500, refractory duration in ms after a reward, before returning to IDLE.
- CNT_W, 16, width of reward_count and of the timeout field.

Ports:
- clk  in  1  system clock (clk_1mhz)
- reset_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle pulse (okTriggerIn, clk domain); starts a trial
- arm_port  in  2  port index sampled on arm
- timeout_ms  in  CNT_W  trial timeout in ms, sampled on arm; 0 = no timeout
- abort  in  1  one-cycle pulse; cancels a trial
- lick  in  4  debounced lick levels, active-high, already synchronous to clk
- valve_trig  out  4  one-cycle pulse to valve_driver start inputs
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a trial ends, for any outcome
- outcome  out  2  0=NONE, 1=REWARD, 2=TIMEOUT, 3=ABORT; held until the next arm
- wrong_licks  out  8  count of lick rising edges on non-armed ports in the current trial; saturates at 255
- reward_count  out  CNT_W  total rewards since reset; wraps

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; internal registers 0.
- Edge detect: lick_q registered each cycle. rise = lick & ~lick_q.
- ms tick: prescaler counts 0..MS_DIV-1 and pulses tick on wrap. The prescaler clears on arm, so ms timing is aligned to arm.
- States: IDLE, ARMED, REWARD, REFRACT.
- IDLE:
  - On arm, latch port and timeout; clear wrong_licks; outcome=NONE; go to ARMED next cycle.
  - abort in IDLE is ignored.
- ARMED:
  - Only rising edges count. A lick held high at arm does not reward.
  - rise[port] → REWARD.
  - rise on any other port → wrong_licks+1 (saturating). Multiple simultaneous wrong rises count as 1.
  - If timeout≠0, the ms counter increments on tick. When it reaches timeout: outcome=TIMEOUT, done, go to IDLE.
  - abort: outcome=ABORT, done, go to IDLE. If abort coincides with a correct rise or timeout in the same cycle, abort wins.
  - If a correct rise and timeout expiry coincide, the reward wins.
  - arm while busy is ignored; no re-arm.
- REWARD (exactly 1 cycle):
  - valve_trig[port]=1; all other valve_trig bits 0.
  - reward_count+1; outcome=REWARD; go to REFRACT.
  - Latency: rise seen in ARMED at cycle N → valve_trig high at cycle N+1.
- REFRACT:
  - Counts REFRACT_MS ticks, then done and go to IDLE.
  - Licks are ignored.
  - abort → go to IDLE immediately, with done. outcome stays REWARD.
- valve_trig is never high outside REWARD. At most one bit is high at a time.
- done fires exactly once per armed trial.

Decomposition:
- Shared package holds:
  - State encoding (IDLE=0, ARMED=1, REWARD=2, REFRACT=3).
  - Outcome codes (NONE/REWARD/TIMEOUT/ABORT).
  - Default MS_DIV.
- Natural sub-module: ms_timer.
  - Holds the prescaler plus the ms counter.
  - Ports: clear, enable, limit, expired.
  - Used for both timeout and refractory timing.

Test Plan:
- Reset mid-ARMED: assert reset_n=0 → busy=0, valve_trig=0, outcome=0, reward_count=0 immediately.
- arm port=2, timeout=100, lick[2] rises at 40 ms → valve_trig=4'b0100 for 1 cycle, one cycle after the rise; outcome=1; reward_count=1; done 500 ms later.
- arm port=1, timeout=5, no licks → done with outcome=2 at 5000±1 cycles after arm; valve_trig stays 0.
- lick[0] held high across arm port=0, then 3 rises on lick[3], then lick[0] falls and rises → wrong_licks=3; reward only on the second lick[0] edge.
- arm port=0, timeout=0; abort at 1 s → outcome=3, done; a later lick[0] produces no valve_trig. Correct rise and abort in the same cycle → outcome=3, no trigger.
- arm during REFRACT is ignored: no state change, reward_count unchanged. After 300 wrong rises, wrong_licks=255.
